// File: rtl/seq_chunk_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice is reused NCHUNK times,
// with the carry registered between chunks and a start/done handshake around it.
module seq_chunk_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  opA_q;
    logic [WIDTH-1:0]  opB_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic [CHUNK-1:0]  sliceA;
    logic [CHUNK-1:0]  sliceB;
    logic [CHUNK-1:0]  sliceSum;
    logic              sliceCarry;
    logic              accept;

    // The single shared ripple slice, steered by the current chunk index.
    always_comb begin
        sliceA = opA_q[int'(idx_q) * CHUNK +: CHUNK];
        sliceB = opB_q[int'(idx_q) * CHUNK +: CHUNK];
        {sliceCarry, sliceSum} = {1'b0, sliceA} + {1'b0, sliceB} + {{CHUNK{1'b0}}, carry_q};
        accept = start && (state_q != RUN);
    end

    // A new request may start from IDLE or straight out of DONE, giving back-to-back
    // operation. Subtraction is folded into addition by inverting B and forcing carry-in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            state_q <= RUN;
            idx_q   <= '0;
            opA_q   <= a;
            opB_q   <= b ^ {WIDTH{sub}};
            carry_q <= sub ? 1'b1 : cin;
        end else begin
            case (state_q)
                RUN: begin
                    sum_q[int'(idx_q) * CHUNK +: CHUNK] <= sliceSum;
                    carry_q <= sliceCarry;
                    if (idx_q == LAST_IDX) begin
                        // Top slice writes sum MSB this edge, so use the slice output directly.
                        state_q <= DONE;
                        idx_q   <= '0;
                        cout_q  <= sliceCarry;
                        ovf_q   <= (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &&
                                   (sliceSum[CHUNK-1] != opA_q[WIDTH-1]);
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_addsub.sv
// Bench for seq_chunk_addsub: three builds (CHUNK 4, 16, 1) share one stimulus stream and
// are compared every cycle against a cycle-count/arithmetic reference.
module tb_seq_chunk_addsub;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [15:0]      a;
    logic [15:0]      b;
    logic             cin;
    logic             sub;
    logic [2:0]       busyV;
    logic [2:0]       doneV;
    logic [2:0]       coutV;
    logic [2:0]       ovfV;
    logic [2:0][15:0] sumV;

    int checks = 0;
    int errors = 0;

    bit          mRun [3];
    bit          mDone [3];
    int          mLeft [3];
    logic [15:0] mSum [3];
    logic        mCout [3];
    logic        mOvf [3];
    logic [15:0] pSum [3];
    logic        pCout [3];
    logic        pOvf [3];
    int          busyCnt [3];
    int          doneCnt [3];
    int          opsDone [3];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : gDut
            localparam int CHK = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
            seq_chunk_addsub #(.WIDTH(16), .CHUNK(CHK)) dut (
                .clk   (clk),
                .rst   (rst),
                .start (start),
                .a     (a),
                .b     (b),
                .cin   (cin),
                .sub   (sub),
                .busy  (busyV[g]),
                .done  (doneV[g]),
                .sum   (sumV[g]),
                .cout  (coutV[g]),
                .ovf   (ovfV[g])
            );
        end
    endgenerate

    function automatic int nChunk(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    endfunction

    // Plain integer arithmetic: unsigned result/carry and true signed range overflow.
    task automatic referenceResult(input logic [15:0] aIn, input logic [15:0] bIn,
                                   input logic cIn, input logic sIn,
                                   output logic [15:0] r, output logic co, output logic ov);
        int u;
        int sr;
        if (sIn) begin
            u  = int'(aIn) - int'(bIn);
            sr = int'($signed(aIn)) - int'($signed(bIn));
            co = (aIn >= bIn);
        end else begin
            u  = int'(aIn) + int'(bIn) + int'(cIn);
            sr = int'($signed(aIn)) + int'($signed(bIn)) + int'(cIn);
            co = (u > 65535);
        end
        r  = u[15:0];
        ov = (sr > 32767) || (sr < -32768);
    endtask

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s[inst%0d] at %0t: got %h expected %h", name, g, $time, act, exp);
        end
    endtask

    // Reference: a request is taken whenever the unit is not mid-operation; it then stays busy
    // for NCHUNK cycles and raises done for exactly one cycle.
    task automatic modelStep();
        logic [15:0] r;
        logic co;
        logic ov;
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                mRun[g] = 0; mDone[g] = 0; mLeft[g] = 0;
                mSum[g] = '0; mCout[g] = 1'b0; mOvf[g] = 1'b0;
            end else if (!mRun[g] && start) begin
                referenceResult(a, b, cin, sub, r, co, ov);
                pSum[g] = r; pCout[g] = co; pOvf[g] = ov;
                mRun[g] = 1; mDone[g] = 0; mLeft[g] = nChunk(g);
            end else if (mRun[g]) begin
                mLeft[g]--;
                if (mLeft[g] == 0) begin
                    mRun[g] = 0; mDone[g] = 1;
                    mSum[g] = pSum[g]; mCout[g] = pCout[g]; mOvf[g] = pOvf[g];
                    opsDone[g]++;
                end
            end else begin
                mDone[g] = 0;
            end
        end
    endtask

    task automatic checkOutput();
        for (int g = 0; g < 3; g++) begin
            if (busyV[g]) busyCnt[g]++;
            if (doneV[g]) doneCnt[g]++;
            check("busy", g, 32'(busyV[g]), 32'(mRun[g]));
            check("done", g, 32'(doneV[g]), 32'(mDone[g]));
            if (!mRun[g]) begin
                check("sum", g, 32'(sumV[g]), 32'(mSum[g]));
                check("cout", g, 32'(coutV[g]), 32'(mCout[g]));
                check("ovf", g, 32'(ovfV[g]), 32'(mOvf[g]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic clearCounts();
        for (int g = 0; g < 3; g++) begin
            busyCnt[g] = 0;
            doneCnt[g] = 0;
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((mRun[0] || mRun[1] || mRun[2]) && n < 200) begin
            tick();
            n++;
        end
        check("settle", 0, 32'(busyV), 32'(0));
    endtask

    task automatic applyStimulus(input logic [15:0] aIn, input logic [15:0] bIn,
                                 input logic cIn, input logic sIn);
        a = aIn; b = bIn; cin = cIn; sub = sIn; start = 1'b1;
        tick();
        start = 1'b0;
        waitIdle();
    endtask

    task automatic expectResult(input int g, input logic [15:0] s, input logic co, input logic ov);
        check("litSum", g, 32'(sumV[g]), 32'(s));
        check("litCout", g, 32'(coutV[g]), 32'(co));
        check("litOvf", g, 32'(ovfV[g]), 32'(ov));
        check("modelSum", g, 32'(mSum[g]), 32'(s));
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int g = 0; g < 3; g++) opsDone[g] = 0;
        clearCounts();
        tick();
        tick();
        check("resetSum", 0, 32'(sumV[0]), 32'(0));
        check("resetBusy", 0, 32'(busyV), 32'(0));
        check("resetDone", 0, 32'(doneV), 32'(0));
        rst = 1'b0;
        tick();

        clearCounts();
        applyStimulus(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            expectResult(g, 16'h2233, 1'b0, 1'b0);
            check("donePulses", g, 32'(doneCnt[g]), 32'(1));
        end
        check("busyCycles", 0, 32'(busyCnt[0]), 32'(4));
        check("busyCycles", 1, 32'(busyCnt[1]), 32'(1));
        check("busyCycles", 2, 32'(busyCnt[2]), 32'(16));

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) expectResult(g, 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) expectResult(g, 16'h8000, 1'b0, 1'b1);
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
        for (int g = 0; g < 3; g++) expectResult(g, 16'hFFFE, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
        for (int g = 0; g < 3; g++) expectResult(g, 16'h7FFF, 1'b1, 1'b1);
        applyStimulus(16'hABCD, 16'h1111, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) expectResult(g, 16'hBCDE, 1'b0, 1'b0);

        // Mid-run request: ignored by the 4- and 1-bit builds, taken by the 16-bit build in DONE.
        a = 16'h1234; b = 16'h0FFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        waitIdle();
        expectResult(0, 16'h2233, 1'b0, 1'b0);
        expectResult(2, 16'h2233, 1'b0, 1'b0);
        expectResult(1, 16'hFFFE, 1'b1, 1'b0);

        // Start held through done: the 4-bit build takes the second op in its done cycle.
        clearCounts();
        a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        a = 16'h0010; b = 16'h0001; sub = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        start = 1'b0;
        waitIdle();
        expectResult(0, 16'h000F, 1'b1, 1'b0);
        expectResult(1, 16'h000F, 1'b1, 1'b0);
        expectResult(2, 16'h0003, 1'b0, 1'b0);
        check("b2bBusy", 0, 32'(busyCnt[0]), 32'(8));
        check("b2bDone", 0, 32'(doneCnt[0]), 32'(2));
        check("b2bDone", 1, 32'(doneCnt[1]), 32'(3));
        check("b2bDone", 2, 32'(doneCnt[2]), 32'(1));

        // Reset during the second RUN cycle aborts without a done pulse.
        clearCounts();
        a = 16'h4321; b = 16'h1111; cin = 1'b1; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abortBusy", 0, 32'(busyV[0]), 32'(0));
        check("abortDone", 0, 32'(doneV[0]), 32'(0));
        check("abortSum", 0, 32'(sumV[0]), 32'(0));
        for (int i = 0; i < 20; i++) tick();
        check("abortNoDone", 0, 32'(doneCnt[0]), 32'(0));
        check("abortNoDone", 2, 32'(doneCnt[2]), 32'(0));

        for (int g = 0; g < 3; g++) opsDone[g] = 0;
        for (int cyc = 0; cyc < 60000 && opsDone[2] < 1000; cyc++) begin
            rst   = ($urandom_range(0, 1999) == 0);
            start = ($urandom_range(0, 3) != 0);
            a     = pick();
            b     = pick();
            cin   = 1'($urandom_range(0, 1));
            sub   = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0; start = 1'b0;
        waitIdle();
        check("randomOps", 2, 32'(opsDone[2] >= 1000), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
